conv_window_gen: RTL and testbench

//  Builds a 3x3 sliding pixel window from a raster pixel stream, using two line buffers.

---
 rtl/conv_window_gen_pkg.sv | 20 ++
 rtl/conv_window_gen_if.sv | 23 ++
 rtl/conv_window_gen_line_ram.sv | 22 ++
 rtl/conv_window_gen.sv | 139 +++++++++++++
 tb/tb_conv_window_gen.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_window_gen_pkg.sv
// Shared constants and helpers for the 3x3 window generator.
// Optional feature macro honoured by this slice: CONV_ZERO_PAD_EN.
`ifndef CONV_WINDOW_GEN_PKG_SV
`define CONV_WINDOW_GEN_PKG_SV

`define CONV_WIN_W(dw) (conv_window_gen_pkg::NU * (dw))

package conv_window_gen_pkg;

    localparam int KS = 3;
    localparam int NU = KS * KS;

    // Flat tap index of window column c, window row r (0 = oldest in both).
    function automatic int tap(input int c, input int r);
        return c * KS + r;
    endfunction

endpackage

`endif

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bundle between the raster source, the window generator and the MAC.
interface conv_window_gen_if
    import conv_window_gen_pkg::*;
#(
    parameter int DW = 10
);
    logic                 sof;
    logic                 in_vld;
    logic [DW-1:0]        in_dat;
    logic                 win_vld;
    logic [NU*DW-1:0]     win;
    logic                 eof;

    modport master (
        output sof, in_vld, in_dat,
        input  win_vld, win, eof
    );

    modport slave (
        input  sof, in_vld, in_dat,
        output win_vld, win, eof
    );
endinterface

// File: rtl/conv_window_gen_line_ram.sv
// One image line of pixel storage: synchronous write, asynchronous read at the same address.
module conv_line_ram #(
    parameter int DW    = 10,
    parameter int DEPTH = 640,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdat,
    output logic [DW-1:0] rdat
);
    logic [DW-1:0] mem [DEPTH];

    // Read returns the old word during a write cycle, which is what lets
    // lb0 feed lb1 at the same column without a separate read port.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdat;
    end

    assign rdat = mem[addr];
endmodule

// File: rtl/conv_window_gen.sv
// 3x3 sliding window over a raster stream: two line buffers, a 3x3 shift register, col/row tracking.
// Build option CONV_ZERO_PAD_EN: emit a window for every pixel with causal zero padding.
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int DW = 10,
    parameter int IW = 640,
    parameter int IH = 480
) (
    input logic              clk,
    input logic              rst,
    conv_window_gen_if.slave io
);
    localparam int CW = $clog2(IW);
    localparam int RW = $clog2(IH);
    localparam int WIN_W = `CONV_WIN_W(DW);
    localparam logic [CW-1:0] COL_LAST = CW'(IW - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IH - 1);

    // [window col][window row][bit]; flattening gives tap(c,r)*DW offsets directly.
    typedef logic [KS-1:0][KS-1:0][DW-1:0] wnd_t;

    logic [CW-1:0] col_q, col_d, pos_col;
    logic [RW-1:0] row_q, row_d, pos_row;
    logic          sync_q, sync_d;
    logic          win_vld_q, win_vld_d;
    logic          eof_q, eof_d;
    wnd_t          wnd_q, wnd_d;
    logic          accept;
    logic [DW-1:0] lb0_rd, lb1_rd;

    // Until a sof has been seen since reset, the position is unknown and the stream is dropped.
    assign accept  = io.in_vld & (io.sof | sync_q);
    assign pos_col = io.sof ? '0 : col_q;
    assign pos_row = io.sof ? '0 : row_q;

    conv_line_ram #(.DW(DW), .DEPTH(IW), .AW(CW)) u_lb0 (
        .clk  (clk),
        .we   (accept),
        .addr (pos_col),
        .wdat (io.in_dat),
        .rdat (lb0_rd)
    );

    conv_line_ram #(.DW(DW), .DEPTH(IW), .AW(CW)) u_lb1 (
        .clk  (clk),
        .we   (accept),
        .addr (pos_col),
        .wdat (lb0_rd),
        .rdat (lb1_rd)
    );

    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        sync_d    = sync_q;
        win_vld_d = 1'b0;
        eof_d     = 1'b0;
        wnd_d     = wnd_q;

        if (accept) begin
            sync_d   = 1'b1;
            wnd_d[0] = wnd_q[1];
            wnd_d[1] = wnd_q[2];
            wnd_d[2][0] = lb1_rd;
            wnd_d[2][1] = lb0_rd;
            wnd_d[2][2] = io.in_dat;

            if (pos_col == COL_LAST) begin
                col_d = '0;
                if (pos_row == ROW_LAST) begin
                    row_d = '0;
                    eof_d = 1'b1;
                end else begin
                    row_d = pos_row + RW'(1);
                end
            end else begin
                col_d = pos_col + CW'(1);
                row_d = pos_row;
            end

`ifdef CONV_ZERO_PAD_EN
            win_vld_d = 1'b1;
`else
            // Columns 0 and 1 still hold the previous line's tail, so they never qualify.
            win_vld_d = (pos_row >= RW'(2)) && (pos_col >= CW'(2));
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q     <= '0;
            row_q     <= '0;
            sync_q    <= 1'b0;
            win_vld_q <= 1'b0;
            eof_q     <= 1'b0;
            wnd_q     <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            sync_q    <= sync_d;
            win_vld_q <= win_vld_d;
            eof_q     <= eof_d;
            wnd_q     <= wnd_d;
        end
    end

`ifdef CONV_ZERO_PAD_EN
    logic [WIN_W-1:0] win_q, win_d;

    // The shift register keeps raw history; only the output copy is masked,
    // since a tap masked now becomes a real in-frame tap a few pixels later.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            win_d = wnd_d;
            for (int c = 0; c < KS; c++) begin
                for (int r = 0; r < KS; r++) begin
                    if ((int'(pos_row) + r < KS - 1) || (int'(pos_col) + c < KS - 1))
                        win_d[tap(c, r)*DW +: DW] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) win_q <= '0;
        else      win_q <= win_d;
    end

    assign io.win = win_q;
`else
    assign io.win = WIN_W'(wnd_q);
`endif

    assign io.win_vld = win_vld_q;
    assign io.eof     = eof_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: image model + per-cycle compare, plus literal window checks.
module tb_conv_window_gen;
    import conv_window_gen_pkg::*;

    localparam int DW = 10;
    localparam int IW = 8;
    localparam int IH = 6;
    localparam int WW = `CONV_WIN_W(DW);
`ifdef CONV_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    conv_window_gen_if #(.DW(DW)) bus ();

    conv_window_gen #(.DW(DW), .IW(IW), .IH(IH)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int test = 0;
    bit chk_en = 1'b0;
    int n_win = 0, n_eof = 0, n_b2b = 0;
    bit prev_vld = 1'b0;

    // Model state: image seen so far, position tracking, expected outputs.
    logic [DW-1:0] img [IH][IW];
    bit            m_sync = 1'b0;
    int            m_row = 0, m_col = 0;
    logic          exp_vld = 1'b0, exp_eof = 1'b0;
    logic [WW-1:0] exp_win = '0;

    task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] tapof(input logic [WW-1:0] w, input int i);
        return w[i*DW +: DW];
    endfunction

    function automatic int count_val(input logic [WW-1:0] w, input logic [DW-1:0] v);
        int n = 0;
        for (int i = 0; i < NU; i++) if (tapof(w, i) == v) n++;
        return n;
    endfunction

    function automatic logic [DW-1:0] pv(input int r, input int c, input int off);
        return DW'(off + r * 16 + c + 1);
    endfunction

    // Window for pixel (r,c): rows r-2..r, cols c-2..c; out-of-image sources read as 0.
    function automatic logic [WW-1:0] model_win(input int r, input int c);
        logic [WW-1:0] w = '0;
        for (int tc = 0; tc < 3; tc++)
            for (int tr = 0; tr < 3; tr++)
                if (r - 2 + tr >= 0 && c - 2 + tc >= 0)
                    w[(tc*3 + tr)*DW +: DW] = img[r-2+tr][c-2+tc];
        return w;
    endfunction

    task automatic cyc(input bit s, input bit v, input logic [DW-1:0] d);
        int r, c;
        bus.sof = s; bus.in_vld = v; bus.in_dat = d;
        @(posedge clk); #1;
        if (rst && v && (s || m_sync)) begin
            r = s ? 0 : m_row;
            c = s ? 0 : m_col;
            img[r][c] = d;
            m_sync  = 1'b1;
            exp_vld = PAD || (r >= 2 && c >= 2);
            exp_eof = (r == IH - 1) && (c == IW - 1);
            if (exp_vld) exp_win = model_win(r, c);
            if (c == IW - 1) begin
                m_col = 0;
                m_row = (r == IH - 1) ? 0 : r + 1;
            end else begin
                m_col = c + 1;
                m_row = r;
            end
        end else begin
            exp_vld = 1'b0;
            exp_eof = 1'b0;
        end
    endtask

    task automatic hook(input int r, input int c);
        logic [DW-1:0] t1 [9];
        t1 = '{10'h01, 10'h11, 10'h21, 10'h02, 10'h12, 10'h22, 10'h03, 10'h13, 10'h23};
        if (test == 1 && r == 2 && c == 2) begin
            chk("t1_first_vld", bus.win_vld, 1'b1);
            for (int i = 0; i < NU; i++) chk($sformatf("t1_tap%0d", i), tapof(bus.win, i), t1[i]);
            chk("t1_model_tap0", tapof(exp_win, 0), 10'h01);
            chk("t1_model_tap8", tapof(exp_win, 8), 10'h23);
        end
        if (test == 1 && r == IH - 1 && c == IW - 1) begin
            chk("t1_eof", bus.eof, 1'b1);
            chk("t1_last_tap8", tapof(bus.win, 8), 10'h58);
`ifdef CONV_ZERO_PAD_EN
            chk("t1_wins_before_last", n_win, 47);
`else
            chk("t1_wins_before_last", n_win, 23);
`endif
        end
        if (test == 3 && r == 3 && c <= 2) begin
`ifdef CONV_ZERO_PAD_EN
            if (c < 2) for (int i = 0; i < 3; i++) chk($sformatf("t3_pad_c%0d_tap%0d", c, i), tapof(bus.win, i), '0);
            if (c < 2) chk($sformatf("t3_no28_c%0d", c), count_val(bus.win, 10'h28), 0);
`else
            if (c < 2) chk($sformatf("t3_vld_c%0d", c), bus.win_vld, 1'b0);
`endif
            if (c == 2) begin
                chk("t3_tap0", tapof(bus.win, 0), 10'h11);
                chk("t3_tap1", tapof(bus.win, 1), 10'h21);
                chk("t3_tap2", tapof(bus.win, 2), 10'h31);
                chk("t3_no28", count_val(bus.win, 10'h28), 0);
            end
        end
        if (test == 4 && r == 2 && c == 2) begin
            chk("t4_new_tap0", tapof(bus.win, 0), 10'h101);
            chk("t4_new_tap8", tapof(bus.win, 8), 10'h123);
        end
`ifdef CONV_ZERO_PAD_EN
        if (test == 6 && r == 0 && c == 0) begin
            for (int i = 0; i < 8; i++) chk($sformatf("t6_00_tap%0d", i), tapof(bus.win, i), '0);
            chk("t6_00_tap8", tapof(bus.win, 8), 10'h01);
        end
        if (test == 6 && r == 1 && c == 2) begin
            chk("t6_12_tap0", tapof(bus.win, 0), '0);
            chk("t6_12_tap3", tapof(bus.win, 3), '0);
            chk("t6_12_tap6", tapof(bus.win, 6), '0);
            chk("t6_12_tap7", tapof(bus.win, 7), 10'h03);
            chk("t6_12_tap8", tapof(bus.win, 8), 10'h13);
        end
`endif
    endtask

    task automatic frame(input int off, input bit toggle, input int npix);
        for (int i = 0; i < npix; i++) begin
            cyc(i == 0, 1'b1, pv(i / IW, i % IW, off));
            hook(i / IW, i % IW);
            if (toggle) cyc(1'b0, 1'b0, '0);
        end
    endtask

    task automatic clr_cnt();
        n_win = 0; n_eof = 0; n_b2b = 0;
    endtask

    // Per-cycle scoreboard compare, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("win_vld", bus.win_vld, exp_vld);
            chk("eof", bus.eof, exp_eof);
            if (exp_vld) chk("win", bus.win, exp_win);
            if (bus.win_vld) n_win++;
            if (bus.eof) n_eof++;
            if (bus.win_vld && prev_vld) n_b2b++;
            prev_vld = bus.win_vld;
        end
    end

    initial begin
        rst = 1'b0;
        bus.sof = 1'b0; bus.in_vld = 1'b0; bus.in_dat = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_win_vld", bus.win_vld, 1'b0);
        chk("rst_eof", bus.eof, 1'b0);
        chk("rst_win", bus.win, '0);
        rst = 1'b1;
        chk_en = 1'b1;
        cyc(1'b0, 1'b0, '0);

        // Ramp frame, back-to-back; in pad builds this also covers the padded windows.
        test = 1;
`ifdef CONV_ZERO_PAD_EN
        test = 6;
        clr_cnt();
        frame(0, 1'b0, IW * IH);
        chk("t6_count", n_win, IW * IH);
        chk("t6_eof_count", n_eof, 1);
        test = 1;
`endif
        clr_cnt();
        frame(0, 1'b0, IW * IH);
        cyc(1'b0, 1'b0, '0);
        chk("t1_count", n_win, PAD ? IW * IH : (IW - 2) * (IH - 2));
        chk("t1_eof_count", n_eof, 1);

        test = 2;
        clr_cnt();
        frame(0, 1'b1, IW * IH);
        chk("t2_count", n_win, PAD ? IW * IH : (IW - 2) * (IH - 2));
        chk("t2_no_b2b", n_b2b, 0);
        chk("t2_eof_count", n_eof, 1);

        test = 3;
        clr_cnt();
        frame(0, 1'b0, IW * IH);
        cyc(1'b0, 1'b0, '0);

        // Abort after pixel (3,3); the restarted frame uses distinct values.
        test = 0;
        clr_cnt();
        frame(0, 1'b0, 3 * IW + 4);
        chk("t4_abort_eof", n_eof, 0);
        test = 4;
        frame(10'h100, 1'b0, IW * IH);
        cyc(1'b0, 1'b0, '0);
        chk("t4_count", n_win, PAD ? 3 * IW + 4 + IW * IH : 8 + (IW - 2) * (IH - 2));
        chk("t4_eof_count", n_eof, 1);

        // Reset mid-stream with a window on the outputs.
        test = 5;
        frame(0, 1'b0, 2 * IW + 5);
        chk("t5_pre_vld", bus.win_vld, 1'b1);
        #2;
        rst = 1'b0;
        m_sync = 1'b0; m_row = 0; m_col = 0;
        exp_vld = 1'b0; exp_eof = 1'b0; exp_win = '0;
        #1;
        chk("t5_async_vld", bus.win_vld, 1'b0);
        chk("t5_async_eof", bus.eof, 1'b0);
        chk("t5_async_win", bus.win, '0);
        repeat (3) cyc(1'b0, 1'b1, 10'h3ff);
        rst = 1'b1;
        clr_cnt();
        for (int i = 0; i < 5 * IW; i++) cyc(1'b0, 1'b1, pv(i / IW, i % IW, 0));
        chk("t5_ignored", n_win, 0);
        frame(0, 1'b0, IW * IH);
        cyc(1'b0, 1'b0, '0);
        chk("t5_count", n_win, PAD ? IW * IH : (IW - 2) * (IH - 2));
        chk("t5_eof_count", n_eof, 1);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
